dev_bus_ctrl: RTL and testbench
===============================

# dev_bus_ctrl

Parametrised device-bus controller between the CPU core's memory path and NUM_DEV external devices. It is the successor to the single-device memory controller. It accepts one-cycle read/write request pulses from the core, decodes the address into a per-device region and drives a one-hot select with a ready handshake. It returns read data with a push pulse and a completion pulse that re-enables fetch.

## Interface
Parameters:
- NUM_DEV, 4: number of device regions (1..16).
- DATA_W, 32: data width.
- DEV_ADDR_W, 18: word-address bits passed to each device.
- MIN_WAIT, 1: minimum ACCESS cycles per transaction (≥1).
- TIMEOUT, 255: ACCESS-cycle limit; used only with DEV_BUS_TIMEOUT_EN (> MIN_WAIT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- read  in  1  one-cycle read request.
- write  in  1  one-cycle write request.
- addr  in  32  request address.
- data  in  DATA_W  write data.
- q  out  DATA_W  read result, valid while push=1.
- push  out  1  one-cycle pulse: q valid (reads only).
- next  out  1  one-cycle completion pulse (reads and writes).
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle error flag, coincident with next.
- dev_sel  out  NUM_DEV  one-hot device select.
- dev_we  out  1  write strobe, qualified by dev_sel.
- dev_addr  out  DEV_ADDR_W  latched addr[DEV_ADDR_W-1:0].
- dev_data  out  DATA_W  latched write data.
- dev_q  in  NUM_DEV*DATA_W  device read data, device i at bits [i*DATA_W +: DATA_W].
- dev_ready  in  NUM_DEV  device i done; devices without a handshake tie this high.

## Operation
- SEL_W = clog2(NUM_DEV), with a minimum of 1. Device index = addr[DEV_ADDR_W+SEL_W-1:DEV_ADDR_W].
- Mapped: index < NUM_DEV and addr[31:DEV_ADDR_W+SEL_W] == 0. Anything else is unmapped.
- States and transitions:
  - IDLE: on read|write, latch addr, data, kind and index. Mapped → ACCESS; unmapped → DONE with q=0.
  - ACCESS: dev_sel[index]=1, dev_we=kind. Wait counter increments each cycle.
  - ACCESS exit: leaves when counter+1 ≥ MIN_WAIT and dev_ready[index]=1. dev_q slice is captured into q on that edge. → DONE.
  - DONE: next=1; push=1 if read; err per Configuration. → IDLE.
- read and write in the same cycle: write wins, read dropped.
- Requests while busy=1 are ignored; no queueing.
- dev_addr and dev_data hold their latched values until the next accepted request.
- q holds its value after DONE.
- dev_q and dev_ready of unselected devices are ignored.

## Timing
- Reset values: state IDLE. q, push, next, busy, err, dev_sel, dev_we, dev_addr, dev_data and counter are all 0.
- Mapped latency: request sampled at edge 0; ACCESS occupies cycles 1..N with N ≥ MIN_WAIT; next is high in cycle N+1.
  - With MIN_WAIT=1 and ready high: next in cycle 2.
- Unmapped latency: next in cycle 1. No dev_sel is asserted.
- Throughput: a new request is accepted in the cycle after DONE at the earliest.
- Cycle-level behaviour:
  - dev_sel and dev_we are registered and change only on state transitions.
  - dev_sel drops in the DONE cycle.
- Reset mid-operation: next edge returns to IDLE, dev_sel drops, no next/push pulse is produced.
- Wait counter width = clog2(max(MIN_WAIT, TIMEOUT)+1). The counter saturates and never wraps.

## Configuration
- DEV_BUS_TIMEOUT_EN defined:
  - ACCESS exits to DONE when counter reaches TIMEOUT-1 without ready. q=0 and err=1 in that DONE cycle.
  - Unmapped accesses also set err=1.
  - Timeout has priority over a ready arriving in the same cycle.
- DEV_BUS_TIMEOUT_EN undefined:
  - ACCESS waits for ready indefinitely. Unmapped accesses complete with q=0.
  - err is tied 0, and the TIMEOUT parameter is unused.

## Structure
- Shared package dev_bus_pkg holds:
  - state encoding typedef (IDLE, ACCESS, DONE).
  - clog2 helper function.
  - UNMAPPED_Q constant (0).
- One sub-module, dev_bus_decode: combinational addr → {mapped, index}, parametrised on NUM_DEV, DEV_ADDR_W and SEL_W.

## Test plan
- Defaults, ready tied high, read addr 0x0004_0010 with dev_q[1]=0x1234_5678 → dev_sel=4'b0010 in cycle 1, dev_addr=0x00010, push/next in cycle 2, q=0x1234_5678.
- Write addr 0x0000_0003 data 0xA5A5_A5A5, dev_ready[0] held low for 5 cycles → dev_we=1 and dev_sel=4'b0001 for 6 cycles, next one cycle after ready, push stays 0.
- Read addr 0x0010_0000 (upper bits set) → next in cycle 1, q=0, dev_sel never asserted, err=1 only with macro.
- Simultaneous read+write, then a second request while busy → one write performed, second request ignored, exactly one next pulse.
- With DEV_BUS_TIMEOUT_EN and TIMEOUT=8, ready never asserted → DONE after 8 ACCESS cycles, err=1, q=0.
- rst asserted in ACCESS cycle 2 → dev_sel=0 next cycle, no next/push, a fresh read afterwards completes normally.

Source files
------------

// File: rtl/dev_bus_pkg.sv
// dev_bus_pkg: state encoding, width helper and constants shared by the device-bus controller.
// Used by dev_bus_ctrl and dev_bus_decode.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Read data returned for accesses that fall outside every device region.
  localparam int UNMAPPED_Q = 0;

  // Ceiling log2; clog2(1) is 0, so callers apply their own minimum width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dev_bus_decode.sv
// dev_bus_decode: splits the upper address bits into a device index and a mapped flag.
// Purely combinational; the controller registers the outcome on request accept.
module dev_bus_decode
  import dev_bus_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int DEV_ADDR_W = 18,
  parameter int SEL_W      = 2
) (
  input  logic [31-DEV_ADDR_W:0] i_addr_hi,
  output logic                   o_mapped,
  output logic [SEL_W-1:0]       o_index
);

  localparam int HI_W = 32 - DEV_ADDR_W;
  localparam logic [SEL_W:0] NUM_DEV_L = (SEL_W + 1)'(NUM_DEV);

  logic w_upper_zero;
  logic w_index_ok;

  assign o_index = i_addr_hi[SEL_W-1:0];

  // When the index field reaches bit 31 there are no spare upper bits to test.
  generate
    if (HI_W > SEL_W) begin : g_upper
      assign w_upper_zero = (i_addr_hi[HI_W-1:SEL_W] == '0);
    end else begin : g_no_upper
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  assign w_index_ok = ({1'b0, o_index} < NUM_DEV_L);
  assign o_mapped   = w_upper_zero && w_index_ok;

endmodule

// File: rtl/dev_bus_ctrl.sv
// dev_bus_ctrl: routes one-cycle core requests to NUM_DEV device regions with a one-hot
// select and ready handshake. Define DEV_BUS_TIMEOUT_EN to enable access timeout and err.
module dev_bus_ctrl
  import dev_bus_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int DATA_W     = 32,
  parameter int DEV_ADDR_W = 18,
  parameter int MIN_WAIT   = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read,
  input  logic                      write,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         data,
  output logic [DATA_W-1:0]         q,
  output logic                      push,
  output logic                      next,
  output logic                      busy,
  output logic                      err,
  output logic [NUM_DEV-1:0]        dev_sel,
  output logic                      dev_we,
  output logic [DEV_ADDR_W-1:0]     dev_addr,
  output logic [DATA_W-1:0]         dev_data,
  input  logic [NUM_DEV*DATA_W-1:0] dev_q,
  input  logic [NUM_DEV-1:0]        dev_ready
);

  localparam int SEL_W    = (clog2(NUM_DEV) < 1) ? 1 : clog2(NUM_DEV);
  localparam int WAIT_MAX = (MIN_WAIT > TIMEOUT) ? MIN_WAIT : TIMEOUT;
  localparam int CNT_W    = clog2(WAIT_MAX + 1);
  localparam logic [CNT_W:0]   MIN_WAIT_L = (CNT_W + 1)'(MIN_WAIT);
  localparam logic [CNT_W:0]   CNT_ONE    = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_kind;
  logic [DATA_W-1:0]     r_q;
  logic [NUM_DEV-1:0]    r_dev_sel;
  logic                  r_dev_we;
  logic [DEV_ADDR_W-1:0] r_dev_addr;
  logic [DATA_W-1:0]     r_dev_data;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_req;
  logic                  w_mapped;
  logic [SEL_W-1:0]      w_index;
  logic [NUM_DEV-1:0]    w_sel_onehot;
  logic [DATA_W-1:0]     w_q_masked [NUM_DEV];
  logic [DATA_W-1:0]     w_sel_q;
  logic                  w_ready;
  logic                  w_wait_ok;
  logic                  w_timeout;
  logic                  w_ready_exit;
  logic                  w_next;
  logic                  w_push;
  logic                  w_busy;

  dev_bus_decode #(
    .NUM_DEV   (NUM_DEV),
    .DEV_ADDR_W(DEV_ADDR_W),
    .SEL_W     (SEL_W)
  ) u_decode (
    .i_addr_hi(addr[31:DEV_ADDR_W]),
    .o_mapped (w_mapped),
    .o_index  (w_index)
  );

  // Selected device's data and ready come through the registered one-hot select,
  // so unselected devices cannot influence the result.
  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
      assign w_sel_onehot[gi] = (w_index == SEL_W'(gi));
      assign w_q_masked[gi]   = dev_q[gi*DATA_W +: DATA_W] & {DATA_W{r_dev_sel[gi]}};
    end
  endgenerate

  always_comb begin
    w_sel_q = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_sel_q = w_sel_q | w_q_masked[i];
    end
  end

  assign w_req        = read | write;
  assign w_ready      = |(dev_ready & r_dev_sel);
  assign w_wait_ok    = (({1'b0, r_cnt} + CNT_ONE) >= MIN_WAIT_L);
  assign w_ready_exit = w_wait_ok && w_ready && !w_timeout;

`ifdef DEV_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic r_err;

  assign w_timeout = (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_err <= ~w_mapped;
    end else if (r_state == ACCESS) begin
      r_err <= w_timeout;
    end
  end

  assign err = (r_state == DONE) && r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_next       = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_req) begin
          w_state_next = w_mapped ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (w_timeout || w_ready_exit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_next       = 1'b1;
        w_push       = ~r_kind;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the request on accept, count ACCESS cycles, capture read data on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind     <= 1'b0;
      r_q        <= '0;
      r_dev_sel  <= '0;
      r_dev_we   <= 1'b0;
      r_dev_addr <= '0;
      r_dev_data <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_kind     <= write;
            r_dev_addr <= addr[DEV_ADDR_W-1:0];
            r_dev_data <= data;
            r_cnt      <= '0;
            if (w_mapped) begin
              r_dev_sel <= w_sel_onehot;
              r_dev_we  <= write;
            end else begin
              r_q <= DATA_W'(UNMAPPED_Q);
            end
          end
        end
        ACCESS: begin
          if (w_timeout) begin
            r_q       <= DATA_W'(UNMAPPED_Q);
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
          end else if (w_ready_exit) begin
            r_q       <= w_sel_q;
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign q        = r_q;
  assign push     = w_push;
  assign next     = w_next;
  assign busy     = w_busy;
  assign dev_sel  = r_dev_sel;
  assign dev_we   = r_dev_we;
  assign dev_addr = r_dev_addr;
  assign dev_data = r_dev_data;

endmodule

// File: tb/tb_dev_bus_ctrl.sv
// tb_dev_bus_ctrl: directed and random requests against a queue-based reference model,
// with a monitor that pops expectations on every completion pulse.
module tb_dev_bus_ctrl;

  localparam int NUM_DEV    = 4;
  localparam int DATA_W     = 32;
  localparam int DEV_ADDR_W = 18;
  localparam int MIN_WAIT   = 1;
`ifdef DEV_BUS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
  localparam bit TO_EN      = 1'b1;
`else
  localparam int TB_TIMEOUT = 255;
  localparam bit TO_EN      = 1'b0;
`endif

  logic                      clk;
  logic                      rst;
  logic                      read;
  logic                      write;
  logic [31:0]               addr;
  logic [DATA_W-1:0]         data;
  logic [DATA_W-1:0]         q;
  logic                      push;
  logic                      next;
  logic                      busy;
  logic                      err;
  logic [NUM_DEV-1:0]        dev_sel;
  logic                      dev_we;
  logic [DEV_ADDR_W-1:0]     dev_addr;
  logic [DATA_W-1:0]         dev_data;
  logic [NUM_DEV*DATA_W-1:0] dev_q;
  logic [NUM_DEV-1:0]        dev_ready;

  dev_bus_ctrl #(
    .NUM_DEV   (NUM_DEV),
    .DATA_W    (DATA_W),
    .DEV_ADDR_W(DEV_ADDR_W),
    .MIN_WAIT  (MIN_WAIT),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data     (data),
    .q        (q),
    .push     (push),
    .next     (next),
    .busy     (busy),
    .err      (err),
    .dev_sel  (dev_sel),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_data (dev_data),
    .dev_q    (dev_q),
    .dev_ready(dev_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] q;
    bit          err;
    int          issue_cyc;
    int          lat;
    int          sel_cycles;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          sel_cnt = 0;
  logic [31:0] init_mem [NUM_DEV][16];
  logic [31:0] ref_mem  [NUM_DEV][16];
  logic [31:0] dev_mem  [NUM_DEV][16];
  logic        tb_load;
  logic [NUM_DEV-1:0]    cur_sel;
  logic                  cur_we;
  logic [DEV_ADDR_W-1:0] cur_addr;
  logic [31:0]           cur_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Device emulator: small word memory per device, written when selected and ready.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_DEV; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (tb_load) begin
          dev_mem[i][j] <= init_mem[i][j];
        end else if (dev_sel[i] && dev_we && dev_ready[i] && (dev_addr[3:0] == 4'(j))) begin
          dev_mem[i][j] <= dev_data;
        end
      end
    end
  end

  always_comb begin
    dev_q = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_q[i*DATA_W +: DATA_W] = dev_mem[i][dev_addr[3:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(negedge clk) begin
    if (!busy) sel_cnt = 0;
    else if (dev_sel != '0) sel_cnt++;
    if (dev_sel != '0) begin
      chk("dev_sel", 32'(dev_sel), 32'(cur_sel));
      chk("dev_we", 32'(dev_we), 32'(cur_we));
      chk("dev_addr", 32'(dev_addr), 32'(cur_addr));
      if (dev_we) chk("dev_data", dev_data, cur_data);
    end
    if (push && !next) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_without_next: got push=1 next=0 expected push=0");
    end
    if (next) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_next: got next=1 expected no completion");
      end else begin
        mon_e = exp_q.pop_front();
        chk("push", 32'(push), 32'(mon_e.is_read));
        if (mon_e.is_read) chk("q", q, mon_e.q);
        chk("err", 32'(err), 32'(mon_e.err));
        chk("latency", 32'(cyc - mon_e.issue_cyc + 1), 32'(mon_e.lat));
        chk("sel_cycles", 32'(sel_cnt), 32'(mon_e.sel_cycles));
        $display("txn %s q=%h err=%0d lat=%0d", mon_e.is_read ? "RD" : "WR", q, err,
                 cyc - mon_e.issue_cyc + 1);
      end
    end
  end

  // Issues one request from a negedge with busy low; returns at a negedge with busy low.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int stall, input bit intrude, input int rst_at);
    exp_t        e;
    bit          mapped;
    int          tgt;
    int          n;
    int          c;
    logic [31:0] r;
    bit          done;
    mapped = ((a >> DEV_ADDR_W) < NUM_DEV);
    tgt    = mapped ? int'(a >> DEV_ADDR_W) : 0;
    e.is_read = !wr;
    e.q       = 32'h0;
    e.err     = 1'b0;
    if (mapped) begin
      n = (stall + 1 > MIN_WAIT) ? stall + 1 : MIN_WAIT;
      if (TO_EN && n >= TB_TIMEOUT) begin
        n     = TB_TIMEOUT;
        e.err = 1'b1;
      end else if (wr) begin
        ref_mem[tgt][a[3:0]] = d;
      end else begin
        e.q = ref_mem[tgt][a[3:0]];
      end
      e.lat        = n + 1;
      e.sel_cycles = n;
    end else begin
      e.lat        = 1;
      e.sel_cycles = 0;
      e.err        = TO_EN;
    end
    e.issue_cyc = cyc + 1;
    if (rst_at == 0) exp_q.push_back(e);
    cur_sel  = mapped ? NUM_DEV'(1 << tgt) : '0;
    cur_we   = wr;
    cur_addr = a[DEV_ADDR_W-1:0];
    cur_data = d;
    read  = rd;
    write = wr;
    addr  = a;
    data  = d;
    dev_ready = NUM_DEV'($urandom);
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    addr  = $urandom;
    data  = $urandom;
    c     = 1;
    done  = 1'b0;
    while (!done) begin
      r = $urandom;
      if (mapped) r[tgt] = (c > stall);
      dev_ready = r[NUM_DEV-1:0];
      if (intrude && c == 1) begin
        read = 1'b1;
        addr = 32'h0008_0001;
      end
      if (intrude && c == 2) read = 1'b0;
      if (rst_at != 0 && c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (rst_at != 0 && c == rst_at + 1) begin
        chk("rst_dev_sel", 32'(dev_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_next_push", 32'({next, push}), 32'h0);
        rst = 1'b0;
      end
      if (!busy) begin
        done = 1'b1;
      end else if (c >= 400) begin
        chk("completion_bound", 32'(c), 32'h0);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd;
    bit          wr;
    logic [31:0] a;
    for (int i = 0; i < NUM_DEV; i++) begin
      for (int j = 0; j < 16; j++) begin
        init_mem[i][j] = $urandom;
      end
    end
    init_mem[1][0] = 32'h1234_5678;
    ref_mem  = init_mem;
    rst       = 1'b1;
    tb_load   = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    addr      = 32'h0;
    data      = 32'h0;
    dev_ready = '1;
    cur_sel   = '0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tb_load = 1'b0;
    @(negedge clk);
    chk("reset_q", q, 32'h0);
    chk("reset_push_next", 32'({push, next}), 32'h0);
    chk("reset_busy_err", 32'({busy, err}), 32'h0);
    chk("reset_dev_sel", 32'(dev_sel), 32'h0);
    chk("reset_dev_we", 32'(dev_we), 32'h0);
    chk("reset_dev_addr", 32'(dev_addr), 32'h0);
    chk("reset_dev_data", dev_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 1'b0, 32'h0004_0010, 32'h0, 0, 1'b0, 0);
    do_req(1'b0, 1'b1, 32'h0000_0003, 32'hA5A5_A5A5, 5, 1'b0, 0);
    do_req(1'b1, 1'b0, 32'h0000_0003, 32'h0, 0, 1'b0, 0);
    do_req(1'b1, 1'b0, 32'h0010_0000, 32'h0, 0, 1'b0, 0);
    do_req(1'b1, 1'b1, 32'h0008_0007, 32'hDEAD_BEEF, 0, 1'b1, 0);
    do_req(1'b1, 1'b0, 32'h0008_0007, 32'h0, 0, 1'b0, 0);
`ifdef DEV_BUS_TIMEOUT_EN
    do_req(1'b1, 1'b0, 32'h000C_0005, 32'h0, 1000, 1'b0, 0);
`endif
    do_req(1'b1, 1'b0, 32'h0004_0020, 32'h0, 10, 1'b0, 2);
    do_req(1'b1, 1'b0, 32'h0004_0010, 32'h0, 0, 1'b0, 0);

    for (int t = 0; t < 80; t++) begin
      rd = $urandom_range(0, 1);
      wr = !rd || ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) begin
        a = (32'($urandom_range(0, NUM_DEV - 1)) << DEV_ADDR_W) | ($urandom & 32'h0003_FFFF);
      end else begin
        a = $urandom | 32'h0010_0000;
      end
      do_req(rd, wr, a, $urandom, $urandom_range(0, 4), 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
